// File: rtl/stage_wb_skid.sv
// MEM->WB pipeline stage with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and same-beat write-collision resolution across lanes.
module stage_wb_skid #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR   = 3,
    parameter int unsigned LANES      = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0]              in_wen,
    input  logic [LANES*REG_ADDR-1:0]     in_waddr,
    input  logic [LANES*DATA_WIDTH-1:0]   in_wdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0]              out_wen,
    output logic [LANES*REG_ADDR-1:0]     out_waddr,
    output logic [LANES*DATA_WIDTH-1:0]   out_wdata
);

    localparam int unsigned AW = LANES * REG_ADDR;
    localparam int unsigned DW = LANES * DATA_WIDTH;

    // Main entry (drives outputs) and skid entry
    logic             m_valid, s_valid;
    logic [LANES-1:0] m_wen,   s_wen;
    logic [AW-1:0]    m_waddr, s_waddr;
    logic [DW-1:0]    m_wdata, s_wdata;

    logic             m_valid_n, s_valid_n;
    logic [LANES-1:0] m_wen_n,   s_wen_n;
    logic [AW-1:0]    m_waddr_n, s_waddr_n;
    logic [DW-1:0]    m_wdata_n, s_wdata_n;

    logic             accept_c;
    logic             drain_c;
    logic [LANES-1:0] cap_wen_c;

    // Collision resolution: a lower lane loses its enable to any higher lane writing the same register
    always_comb begin
        cap_wen_c = in_wen;
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned j = i + 1; j < LANES; j++) begin
                if (in_wen[i] && in_wen[j] &&
                    (in_waddr[i*REG_ADDR +: REG_ADDR] == in_waddr[j*REG_ADDR +: REG_ADDR])) begin
                    cap_wen_c[i] = 1'b0;
                end
            end
        end
    end

    assign accept_c = in_valid & ~s_valid;
    assign drain_c  = m_valid & out_ready;

    // Next-state for both entries; flush overrides every other transition
    always_comb begin
        m_valid_n = m_valid;
        m_wen_n   = m_wen;
        m_waddr_n = m_waddr;
        m_wdata_n = m_wdata;
        s_valid_n = s_valid;
        s_wen_n   = s_wen;
        s_waddr_n = s_waddr;
        s_wdata_n = s_wdata;

        if (flush) begin
            m_valid_n = 1'b0;
            s_valid_n = 1'b0;
        end else if (drain_c && s_valid) begin
            // Skid entry moves forward; upstream is stalled this cycle
            m_valid_n = 1'b1;
            m_wen_n   = s_wen;
            m_waddr_n = s_waddr;
            m_wdata_n = s_wdata;
            s_valid_n = 1'b0;
        end else if (drain_c || !m_valid) begin
            // Main entry is free or emptying: capture straight into it
            m_valid_n = accept_c;
            if (accept_c) begin
                m_wen_n   = cap_wen_c;
                m_waddr_n = in_waddr;
                m_wdata_n = in_wdata;
            end
        end else if (accept_c) begin
            // Main entry stalled: park the incoming beat in the skid entry
            s_valid_n = 1'b1;
            s_wen_n   = cap_wen_c;
            s_waddr_n = in_waddr;
            s_wdata_n = in_wdata;
        end
    end

    // Entry registers with defined zero reset values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_wen   <= '0;
            m_waddr <= '0;
            m_wdata <= '0;
            s_valid <= 1'b0;
            s_wen   <= '0;
            s_waddr <= '0;
            s_wdata <= '0;
        end else begin
            m_valid <= m_valid_n;
            m_wen   <= m_wen_n;
            m_waddr <= m_waddr_n;
            m_wdata <= m_wdata_n;
            s_valid <= s_valid_n;
            s_wen   <= s_wen_n;
            s_waddr <= s_waddr_n;
            s_wdata <= s_wdata_n;
        end
    end

    // Outputs are pure functions of the entry flops
    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_wen   = m_wen & {LANES{m_valid}};
    assign out_waddr = m_waddr;
    assign out_wdata = m_wdata;

endmodule
